shift_arbiter: RTL
==================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 0: round-robin pointer value loaded at reset (0 = req0 has first priority, 1 = req1).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1: requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1: operation accepted this cycle.
REQ-006 SHALL have ports reqN_A, input, 32: operand, for N = 0 and 1.
REQ-007 SHALL have ports reqN_B, input, 5: shift amount, for N = 0 and 1.
REQ-008 SHALL have ports reqN_Sel, input, 2: shift mode, for N = 0 and 1.
REQ-009 SHALL have port rsp_valid, output, 1: result available.
REQ-010 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port rsp_Y, output, 32: shift result.
REQ-012 SHALL have port rsp_id, output, 1: index of the requester that owns rsp_Y.

Function
REQ-013 SHALL instantiate exactly one shifter_32bits and time-share it between the two requesters.
REQ-014 SHALL use these Sel modes: 00 logical right shift; 01 arithmetic right shift; 10 and 11 logical left shift.
REQ-015 SHALL implement an FSM with states IDLE, EXEC and RESP; the reset state SHALL be IDLE.
REQ-016 SHALL allow a grant only in IDLE, or in RESP when rsp_ready=1.
REQ-017 SHALL drive reqN_ready=1 combinationally, in a grant-capable cycle, for the granted requester only; at most one ready SHALL be high per cycle.
REQ-018 SHALL grant with the following arbitration:
- only one valid: that requester is granted;
- both valid: the requester selected by the pointer is granted;
- after each grant, the pointer is set to the non-granted index.
REQ-019 SHALL, on a handshake (valid & ready), register A, B, Sel and the requester id, and then enter EXEC.
REQ-020 SHALL, in EXEC, register the shifter output into rsp_Y and enter RESP; rsp_valid SHALL go high 2 cycles after the accept edge.
REQ-021 SHALL, in RESP, hold rsp_valid, rsp_Y and rsp_id stable until rsp_ready=1.
REQ-022 SHALL, when rsp_ready=1 in RESP, go to EXEC if a new grant occurs in that cycle, otherwise to IDLE.
REQ-023 SHALL, when back-to-back operations occur, deassert rsp_valid for the single EXEC cycle between results.
REQ-024 SHALL not change a pending grant decision when requester inputs change while valid=0.
REQ-025 SHALL ignore reqN_valid while in EXEC, or while in RESP with rsp_ready=0; both ready outputs SHALL be 0 in those cycles.

Reset
REQ-026 SHALL, while rst_n=0, force the following immediately, independent of clk:
- state = IDLE;
- rsp_valid = 0, rsp_Y = 0, rsp_id = 0;
- req0_ready = req1_ready = 0;
- pointer = RR_INIT;
- operand registers = 0.
REQ-027 SHALL discard any operation in EXEC or RESP when reset is asserted mid-operation; no result SHALL be delivered for it after reset release.
REQ-028 SHALL be able to grant in the first clock edge after rst_n deasserts.

Configuration
REQ-029 SHALL, when macro SHIFT_ARB_FIXED_PRIO_EN is defined, grant req0 whenever req0_valid=1, ignoring the pointer; the pointer is then unused.
REQ-030 SHALL, when SHIFT_ARB_FIXED_PRIO_EN is undefined, use round-robin arbitration per REQ-018.

Verification
REQ-031 SHALL cover: req0 A=0x80000010, B=4, Sel=01 -> rsp_Y=0xF8000001, rsp_id=0, rsp_valid 2 cycles after accept.
REQ-032 SHALL cover: req1 A=0x80000010, B=4, Sel=00 -> rsp_Y=0x08000001; req1 A=0x80000001, B=1, Sel=11 -> rsp_Y=0x00000002, rsp_id=1.
REQ-033 SHALL cover: both valid continuously, RR_INIT=0, rsp_ready=1 -> grants alternate 0,1,0,1; results arrive in the same order with matching rsp_id; with SHIFT_ARB_FIXED_PRIO_EN, all grants go to req0.
REQ-034 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_Y/rsp_id stable, both ready outputs 0; rsp_ready=1 with req0_valid=1 -> same-cycle grant, next result 2 cycles later.
REQ-035 SHALL cover: rst_n pulled low during EXEC -> rsp_valid=0, rsp_Y=0 immediately; after release, no stale result appears and the first grant follows RR_INIT.
REQ-036 SHALL cover: req0 A=0x00000001, B=31, Sel=10 -> rsp_Y=0x80000000; B=0, Sel=01, A=0xDEADBEEF -> rsp_Y=0xDEADBEEF.

Source files
------------

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 32-bit shifter through a
// valid/ready handshake. One operation is in flight at a time and moves
// IDLE -> EXEC -> RESP; the result is held in RESP until the consumer takes it.
// Arbitration is round-robin by default. Defining SHIFT_ARB_FIXED_PRIO_EN
// gives req0 fixed priority and removes the round-robin pointer.

module shifter_32bits (
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic [1:0]  sel,
    output logic [31:0] y
);

    // Shift mode decode: 00 logical right, 01 arithmetic right, 1x logical left.
    always_comb begin
        y = a << b;
        case (sel)
            2'b00:   y = a >> b;
            2'b01:   y = 32'($signed(a) >>> b);
            default: y = a << b;
        endcase
    end

endmodule

module shift_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_A,
    input  logic [4:0]  req0_B,
    input  logic [1:0]  req0_Sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_A,
    input  logic [4:0]  req1_B,
    input  logic [1:0]  req1_Sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_Y,
    output logic        rsp_id
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [4:0]  b_q, b_d;
    logic [1:0]  sel_q, sel_d;
    logic        id_q, id_d;
    logic [31:0] rsp_y_q, rsp_y_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] shift_y;

    logic        grant_en;
    logic        gnt;
    logic        gnt_id;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    logic        rr_ptr_q, rr_ptr_d;
`endif

    shifter_32bits u_shifter (
        .a   (a_q),
        .b   (b_q),
        .sel (sel_q),
        .y   (shift_y)
    );

    // Arbitration: who would win, and whether a grant may happen this cycle.
    // rst_n gates the grant so both readies drop the instant reset asserts.
    always_comb begin
        grant_en = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        gnt_id   = ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            gnt_id = rr_ptr_q;
        end else begin
            gnt_id = ~req0_valid;
        end
`endif
        gnt        = grant_en && (req0_valid || req1_valid);
        req0_ready = gnt && !gnt_id;
        req1_ready = gnt && gnt_id;
    end

    // Next-state and datapath load decisions for the IDLE/EXEC/RESP sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        id_d     = id_q;
        rsp_y_d  = rsp_y_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            IDLE, RESP: begin
                if (gnt) begin
                    a_d     = gnt_id ? req1_A   : req0_A;
                    b_d     = gnt_id ? req1_B   : req0_B;
                    sel_d   = gnt_id ? req1_Sel : req0_Sel;
                    id_d    = gnt_id;
                    state_d = EXEC;
                end else if (state_q == RESP && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rsp_y_d  = shift_y;
                rsp_id_d = id_q;
                state_d  = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    // Round-robin pointer moves to the loser after every grant.
    always_comb begin
        rr_ptr_d = gnt ? ~gnt_id : rr_ptr_q;
    end

    // Pointer register, reloaded with RR_INIT on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= RR_INIT;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // State, operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand registers are reset too, so a discarded operation
        // leaves nothing behind that could resurface after reset release.
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            id_q     <= 1'b0;
            rsp_y_q  <= '0;
            rsp_id_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            id_q     <= id_d;
            rsp_y_q  <= rsp_y_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_Y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;

endmodule
